max_pool_stream: RTL

- Streaming, channel-parallel K×K max-pooling engine with stride K.
- Replaces the full-tensor combinational pooler with a raster-order pixel stream: one pixel (all CH channels) per beat on a valid/ready interface.
- Sits between a conv/activation stage and the next layer.
- Holds one output row of partial maxima, not the whole frame.

---
 rtl/max_pool_stream_pkg.sv | 35 +++
 rtl/max_pool_stream_max_cmp_vec.sv | 25 ++
 rtl/max_pool_stream.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/max_pool_stream_pkg.sv
// Shared definitions for the pooling and activation stages: an elementwise max
// with selectable signedness, output-grid sizing, and the pixel-role encoding.
package max_pool_stream_pkg;

    localparam int MAX_DATA_BITS = 64;

    typedef enum logic [1:0] {
        PIX_DISCARD,
        PIX_FIRST,
        PIX_ACCUM,
        PIX_FINAL
    } pix_kind_e;

    function automatic int out_dim(input int n, input int k);
        return n / k;
    endfunction

    // Operands are zero-extended into MAX_DATA_BITS. Flipping the element's sign bit
    // turns a two's-complement compare into an unsigned one. Ties return a.
    function automatic logic [MAX_DATA_BITS-1:0] elem_max(
        input logic [MAX_DATA_BITS-1:0] a,
        input logic [MAX_DATA_BITS-1:0] b,
        input int                       bits,
        input logic                     is_signed
    );
        logic [MAX_DATA_BITS-1:0] bias;
        logic [MAX_DATA_BITS-1:0] key_a;
        logic [MAX_DATA_BITS-1:0] key_b;
        bias  = is_signed ? (MAX_DATA_BITS'(1) << (bits - 1)) : '0;
        key_a = a ^ bias;
        key_b = b ^ bias;
        return (key_b > key_a) ? b : a;
    endfunction

endpackage

// File: rtl/max_pool_stream_max_cmp_vec.sv
// CH-lane combinational maximum of two packed pixels; lane c occupies [c*DATA_BITS +: DATA_BITS].
module max_cmp_vec
    import max_pool_stream_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int CH        = 4,
    parameter int SIGNED    = 1
) (
    input  logic [CH*DATA_BITS-1:0] a,
    input  logic [CH*DATA_BITS-1:0] b,
    output logic [CH*DATA_BITS-1:0] y
);

    always_comb begin
        y = '0;
        for (int c = 0; c < CH; c++) begin
            y[c*DATA_BITS +: DATA_BITS] = DATA_BITS'(elem_max(
                MAX_DATA_BITS'(a[c*DATA_BITS +: DATA_BITS]),
                MAX_DATA_BITS'(b[c*DATA_BITS +: DATA_BITS]),
                DATA_BITS,
                SIGNED != 0));
        end
    end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming KxK, stride-K max pooler over a raster pixel stream. It keeps one output
// row of partial maxima and has a single-entry output register with valid/ready.
module max_pool_stream
    import max_pool_stream_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int CH        = 4,
    parameter int H         = 46,
    parameter int W         = 46,
    parameter int K         = 2,
    parameter int SIGNED    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH*DATA_BITS-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH*DATA_BITS-1:0] out_data,
    output logic                    out_last,
    output logic                    frame_done
);

    localparam int OW  = out_dim(W, K);
    localparam int OH  = out_dim(H, K);
    localparam int CW  = (W > 1) ? $clog2(W) : 1;
    localparam int RW  = (H > 1) ? $clog2(H) : 1;
    localparam int KW  = $clog2(K + 1);
    localparam int OCW = (OW > 1) ? $clog2(OW) : 1;
    localparam int PW  = CH * DATA_BITS;

    logic [CW-1:0]  col;
    logic [CW-1:0]  oc;
    logic [RW-1:0]  row;
    logic [RW-1:0]  orow;
    logic [KW-1:0]  kc;
    logic [KW-1:0]  kr;
    logic [PW-1:0]  row_buf [OW];
    logic [PW-1:0]  entry;
    logic [PW-1:0]  upd_max;
    logic [PW-1:0]  emit_max;
    logic           accept;
    logic           last_window;
    pix_kind_e      kind;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign entry       = row_buf[oc[OCW-1:0]];
    assign last_window = (oc == CW'(OW - 1)) && (orow == RW'(OH - 1));

    max_cmp_vec #(.DATA_BITS(DATA_BITS), .CH(CH), .SIGNED(SIGNED)) u_upd_max (
        .a (entry),
        .b (in_data),
        .y (upd_max)
    );

    max_cmp_vec #(.DATA_BITS(DATA_BITS), .CH(CH), .SIGNED(SIGNED)) u_emit_max (
        .a (entry),
        .b (in_data),
        .y (emit_max)
    );

    // Pixels in the truncated right columns / bottom rows only move the counters.
    always_comb begin
        kind = PIX_DISCARD;
        if ((oc < CW'(OW)) && (orow < RW'(OH))) begin
            if ((kc == '0) && (kr == '0)) begin
                kind = PIX_FIRST;
            end else if ((kc == KW'(K - 1)) && (kr == KW'(K - 1))) begin
                kind = PIX_FINAL;
            end else begin
                kind = PIX_ACCUM;
            end
        end
    end

    // Position within the window (kc/kr) and window index (oc/orow) are tracked
    // alongside col/row, so no divider is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col  <= '0;
            kc   <= '0;
            oc   <= '0;
            row  <= '0;
            kr   <= '0;
            orow <= '0;
        end else if (accept) begin
            if (col == CW'(W - 1)) begin
                col <= '0;
                kc  <= '0;
                oc  <= '0;
                if (row == RW'(H - 1)) begin
                    row  <= '0;
                    kr   <= '0;
                    orow <= '0;
                end else begin
                    row <= row + RW'(1);
                    if (kr == KW'(K - 1)) begin
                        kr   <= '0;
                        orow <= orow + RW'(1);
                    end else begin
                        kr <= kr + KW'(1);
                    end
                end
            end else begin
                col <= col + CW'(1);
                if (kc == KW'(K - 1)) begin
                    kc <= '0;
                    oc <= oc + CW'(1);
                end else begin
                    kc <= kc + KW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (kind == PIX_FIRST) begin
                row_buf[oc[OCW-1:0]] <= in_data;
            end else if (kind == PIX_ACCUM) begin
                row_buf[oc[OCW-1:0]] <= upd_max;
            end
        end
    end

    // A new result may load in the same cycle the previous one is taken, because
    // in_ready already includes out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;
            if (accept && (kind == PIX_FINAL)) begin
                out_valid <= 1'b1;
                out_data  <= emit_max;
                out_last  <= last_window;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
